// File: rtl/gp_register_pkg.sv
// rtl/gp_register_pkg.sv - shared datapath constants for KGP miniRISC state registers
package gp_register_pkg;

  localparam int DATA_W = 32;

endpackage

// File: rtl/gp_register.sv
// rtl/gp_register.sv - single-word register with write enable and synchronous reset
module gp_register
  import gp_register_pkg::*;
#(
  parameter int                 WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             RegWrEnbl,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold is a feedback mux on the flop input; the clock is never gated.
  always_comb begin
    q_d = q_q;
    if (RegWrEnbl) begin
      q_d = D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_gp_register.sv
// tb/tb_gp_register.sv - table-driven self-checking bench for gp_register
module tb_gp_register;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] d;
  logic        we;
  logic [31:0] q;

  logic [7:0]  d2;
  logic        we2;
  logic [7:0]  q2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #10 clk = ~clk;

  gp_register u_dut (
    .clk       (clk),
    .rst       (rst),
    .D         (d),
    .RegWrEnbl (we),
    .Q         (q)
  );

  // Narrow instance with a non-zero reset value shares clk/rst.
  gp_register #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .D         (d2),
    .RegWrEnbl (we2),
    .Q         (q2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic r, input logic w,
                         input logic [31:0] dv, input logic [31:0] ev);
    vec_t v;
    v.name = name;
    v.rst  = r;
    v.we   = w;
    v.d    = dv;
    v.exp  = ev;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) add_vec($sformatf("reset_%0d", i), 1'b1, 1'b1, 32'd5, 32'd0);
    add_vec("load_6",        1'b0, 1'b1, 32'd6,          32'd6);
    add_vec("load_7",        1'b0, 1'b1, 32'd7,          32'd7);
    add_vec("load_8",        1'b0, 1'b1, 32'd8,          32'd8);
    add_vec("hold_d9",       1'b0, 1'b0, 32'd9,          32'd8);
    add_vec("hold_d10",      1'b0, 1'b0, 32'd10,         32'd8);
    add_vec("reen_11",       1'b0, 1'b1, 32'd11,         32'd11);
    add_vec("reen_12",       1'b0, 1'b1, 32'd12,         32'd12);
    add_vec("reen_13",       1'b0, 1'b1, 32'd13,         32'd13);
    add_vec("rst_priority",  1'b1, 1'b1, 32'hFFFF_FFFF,  32'd0);
    add_vec("load_ones",     1'b0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    add_vec("hold_ones",     1'b0, 1'b0, 32'd0,          32'hFFFF_FFFF);
    add_vec("load_zeros",    1'b0, 1'b1, 32'd0,          32'd0);
    add_vec("load_pattern",  1'b0, 1'b1, 32'hA5A5_5A5A,  32'hA5A5_5A5A);
    add_vec("hold_pattern",  1'b0, 1'b0, 32'h0000_0001,  32'hA5A5_5A5A);

    rst = 1'b1;
    we  = 1'b1;
    d   = 32'd5;
    d2  = 8'h3C;
    we2 = 1'b0;

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      we  = vecs[i].we;
      d   = vecs[i].d;
      @(posedge clk);
      #1;
      check(vecs[i].name, q, vecs[i].exp);
      if (i == 0) check("rst_value_w8", {24'd0, q2}, 32'h0000_00A5);
      @(negedge clk);
    end

    // rst pulse entirely between edges must not clear the register
    we = 1'b0;
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    #1 check("rst_pulse_between_edges_now", q, 32'hA5A5_5A5A);
    @(posedge clk);
    #1 check("rst_pulse_between_edges", q, 32'hA5A5_5A5A);
    @(negedge clk);

    // no combinational path from D/RegWrEnbl to Q
    we = 1'b1;
    d  = 32'h0000_1234;
    #1 check("no_comb_path", q, 32'hA5A5_5A5A);
    @(posedge clk);
    #1 check("load_after_comb", q, 32'h0000_1234);
    @(negedge clk);

    // mid-operation reset loses the word, then loading resumes
    rst = 1'b1;
    d   = 32'h0000_0077;
    we2 = 1'b1;
    @(posedge clk);
    #1 check("mid_reset", q, 32'd0);
    check("mid_reset_w8_beats_write", {24'd0, q2}, 32'h0000_00A5);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("load_after_reset", q, 32'h0000_0077);
    check("load_w8", {24'd0, q2}, 32'h0000_003C);
    @(negedge clk);
    we2 = 1'b0;
    d2  = 8'hFF;
    rst = 1'b1;
    @(posedge clk);
    #1 check("reset_w8_again", {24'd0, q2}, 32'h0000_00A5);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("hold_w8", {24'd0, q2}, 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
